int_entry_seq: RTL

CPU-side interrupt entry sequencer: the consumer of the InterruptUnit's `INT`/`NMI`/`IntAddrLSBs` request and the sole driver of `INTACK`. At an instruction boundary it accepts a pending request, stalls the core, and pushes PC then SR. It clears SR (except SCG0), fetches the vector word at `0xFF80 + 2*IntAddrLSBs`, loads PC, and pulses `INTACK` so the InterruptUnit clears the serviced flag. It also performs the reset-vector fetch (`0xFFFE`) after `reset` deasserts.

---
 rtl/int_entry_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/int_entry_seq.sv
// -----------------------------------------------------------------------------
// int_entry_seq
//
// CPU-side interrupt entry sequencer. At an instruction boundary it accepts a
// pending INT (when SR.GIE is set) or NMI and stalls the core with `hold`. It
// then pushes PC and SR, clears SR except the bits in SR_KEEP_MASK, fetches the
// vector word at VEC_BASE + 2*index, loads PC, and pulses INTACK so the
// InterruptUnit can clear the serviced flag. After `reset` deasserts it runs
// the reset-vector fetch (index 63, address 0xFFFE) without touching the stack.
//
// Optional feature macro: INT_LPM_WAKE_EN
//   defined   : requests are also accepted while cpu_off is set, so an enabled
//               interrupt wakes the core from low-power mode. The pushed SR
//               keeps CPUOFF, so RETI drops the core back into LPM.
//   undefined : cpu_off is ignored; acceptance only at instr_boundary.
//
// Ports
//   MCLK            system clock, rising edge
//   reset           asynchronous active-high reset
//   INT, NMI        maskable / non-maskable request pending (level)
//   IntAddrLSBs     winning vector index (63 = reset vector)
//   instr_boundary  core is at an instruction fetch boundary
//   cpu_off         SR.CPUOFF from the core
//   PC, SP, SR      current core registers
//   mem_rdata       bus read data, valid the cycle after mem_re
//   hold            stall the core pipeline
//   INTACK          one-cycle acknowledge to the InterruptUnit
//   mem_addr/mem_wdata/mem_we/mem_re   word bus master
//   sp_we/sp_next, sr_we/sr_next, pc_we/pc_next   core register updates
// -----------------------------------------------------------------------------
module int_entry_seq #(
    parameter logic [15:0] VEC_BASE     = 16'hFF80,
    parameter logic [15:0] SR_KEEP_MASK = 16'h0040
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        INT,
    input  logic        NMI,
    input  logic [5:0]  IntAddrLSBs,
    input  logic        instr_boundary,
    input  logic        cpu_off,
    input  logic [15:0] PC,
    input  logic [15:0] SP,
    input  logic [15:0] SR,
    input  logic [15:0] mem_rdata,
    output logic        hold,
    output logic        INTACK,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        sp_we,
    output logic [15:0] sp_next,
    output logic        sr_we,
    output logic [15:0] sr_next,
    output logic        pc_we,
    output logic [15:0] pc_next
);

    typedef enum logic [2:0] {
        RESET,
        IDLE,
        ACCEPT,
        PUSH_PC,
        PUSH_SR,
        CLR_SR,
        VEC_RD,
        LOAD_PC
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  vec_idx;
    logic [15:0] ret_pc;
    logic [15:0] ret_sr;

    logic        wake;
    logic        accept;
    logic [15:0] sr_snap;
    logic [15:0] sp_dec;
    logic [15:0] vec_addr;

    // Inputs that only some builds or bit positions consume.
    logic        unused_bits;
    assign unused_bits = ^{cpu_off, mem_rdata[0]};

`ifdef INT_LPM_WAKE_EN
    assign wake    = instr_boundary || cpu_off;
    // Make sure the stacked SR carries CPUOFF so RETI re-enters LPM.
    assign sr_snap = SR | {11'd0, cpu_off, 4'd0};
`else
    assign wake    = instr_boundary;
    assign sr_snap = SR;
`endif

    // NMI ignores GIE (SR[3]).
    assign accept   = wake && (NMI || (INT && SR[3]));

    // Stack grows down by one word; bit 0 is forced low so a misaligned SP
    // realigns on the first decrement.
    assign sp_dec   = (SP - 16'd2) & 16'hFFFE;
    assign vec_addr = VEC_BASE + {9'd0, vec_idx, 1'b0};

    // State register
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state <= RESET;
        end else begin
            state <= state_next;
        end
    end

    // Latched request context; frozen once ACCEPT has been passed so request
    // changes mid-sequence have no effect.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            vec_idx <= 6'd0;
            ret_pc  <= 16'd0;
            ret_sr  <= 16'd0;
        end else begin
            case (state)
                RESET: begin
                    vec_idx <= 6'd63;
                end
                ACCEPT: begin
                    vec_idx <= IntAddrLSBs;
                    ret_pc  <= PC;
                    ret_sr  <= sr_snap;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = state;
        hold       = 1'b1;
        INTACK     = 1'b0;
        mem_addr   = 16'd0;
        mem_wdata  = 16'd0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        sp_we      = 1'b0;
        sp_next    = 16'd0;
        sr_we      = 1'b0;
        sr_next    = 16'd0;
        pc_we      = 1'b0;
        pc_next    = 16'd0;

        case (state)
            RESET: begin
                // The SR clear belongs to the first cycle after reset falls;
                // while reset is still high every strobe stays low.
                sr_we      = !reset;
                state_next = VEC_RD;
            end
            IDLE: begin
                hold = 1'b0;
                if (accept) begin
                    state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                sp_we      = 1'b1;
                sp_next    = sp_dec;
                state_next = PUSH_PC;
            end
            PUSH_PC: begin
                mem_we     = 1'b1;
                mem_addr   = SP;
                mem_wdata  = ret_pc;
                sp_we      = 1'b1;
                sp_next    = sp_dec;
                state_next = PUSH_SR;
            end
            PUSH_SR: begin
                mem_we     = 1'b1;
                mem_addr   = SP;
                mem_wdata  = ret_sr;
                state_next = CLR_SR;
            end
            CLR_SR: begin
                sr_we      = 1'b1;
                sr_next    = ret_sr & SR_KEEP_MASK;
                state_next = VEC_RD;
            end
            VEC_RD: begin
                mem_re     = 1'b1;
                mem_addr   = vec_addr;
                state_next = LOAD_PC;
            end
            LOAD_PC: begin
                pc_we      = 1'b1;
                pc_next    = {mem_rdata[15:1], 1'b0};
                INTACK     = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule
